// File: rtl/uart_tx_cfg_if.sv
// Valid/ready word handshake between a byte source and uart_tx_cfg.
// The source drives tx_data/tx_valid; the transmitter answers with tx_ready.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter (start, DATA_BITS LSB first, optional parity, 1-2 stop).
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
//
// state      | meaning
// S_IDLE     | line at mark, tx_ready high, waiting for a word
// S_START    | start bit (space)
// S_DATA     | data bits, shift register LSB on the line
// S_PAR      | parity bit (only reachable when PARITY != 0)
// S_STOP     | stop bit(s), mark
// S_BRK      | break held: line at space while tx_break is high
// S_BRK_MARK | one mandatory bit period of mark after a break
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic         tx_break,
`endif
  uart_tx_cfg_if.slave s_if,
  output logic         tx,
  output logic         tx_busy,
  output logic         tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);
  localparam logic             PAR_EN    = (PARITY != 0);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BRK
    , S_BRK_MARK
`endif
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 bit_end;
  logic                 accept;

`ifdef UART_TX_BREAK_EN
  // A pending break outranks a waiting word so it is not starved by a held tx_valid.
  assign s_if.tx_ready = (state_q == S_IDLE) && !tx_break;
`else
  assign s_if.tx_ready = (state_q == S_IDLE);
`endif

  assign accept  = s_if.tx_valid && s_if.tx_ready;
  assign bit_end = (cnt_q == CNT_LAST);
  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= bit_end ? '0 : cnt_q + 1'b1;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (accept) begin
            state_q <= S_START;
            shift_q <= s_if.tx_data;
            par_q   <= (^s_if.tx_data) ^ PAR_ODD;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
`ifdef UART_TX_BREAK_EN
          else if (tx_break) begin
            state_q <= S_BRK;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
`endif
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_q == DATA_LAST) begin
              bit_q   <= '0;
              state_q <= PAR_EN ? S_PAR : S_STOP;
              tx_q    <= PAR_EN ? par_q : 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        S_PAR: begin
          if (bit_end) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_q == STOP_LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BRK: begin
          cnt_q <= '0;
          if (!tx_break) begin
            state_q <= S_BRK_MARK;
            tx_q    <= 1'b1;
          end
        end
        S_BRK_MARK: begin
          if (bit_end) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four frame formats at CLKS_PER_BIT=4, checked cycle by cycle
// against an arithmetic model of the serial waveform.
module tb_uart_tx_cfg;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic [8:0] data_a [4];
  logic [3:0] valid_a;
  logic [3:0] brk_a;
  logic [3:0] rdy_w;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;

  int cfg_db   [4] = '{8, 8, 8, 7};
  int cfg_par  [4] = '{0, 2, 1, 0};
  int cfg_stop [4] = '{1, 1, 1, 2};

  int checks = 0;
  int passes = 0;

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();

  assign if0.tx_data  = data_a[0][7:0];
  assign if1.tx_data  = data_a[1][7:0];
  assign if2.tx_data  = data_a[2][7:0];
  assign if3.tx_data  = data_a[3][6:0];
  assign if0.tx_valid = valid_a[0];
  assign if1.tx_valid = valid_a[1];
  assign if2.tx_valid = valid_a[2];
  assign if3.tx_valid = valid_a[3];
  assign rdy_w = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk_a[0]),
`endif
    .s_if(if0), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk_a[1]),
`endif
    .s_if(if1), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk_a[2]),
`endif
    .s_if(if2), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk_a[3]),
`endif
    .s_if(if3), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame length in clocks: start + data + optional parity + stop bits.
  function automatic int flen(input int k);
    return (1 + cfg_db[k] + ((cfg_par[k] != 0) ? 1 : 0) + cfg_stop[k]) * CPB;
  endfunction

  // Expected line level at clock c (1-based) after acceptance of word d.
  function automatic logic exp_bit(input int k, input logic [8:0] d, input int c);
    int b;
    int ones;
    b = (c - 1) / CPB;
    ones = 0;
    for (int i = 0; i < cfg_db[k]; i++) ones += int'(d[i]);
    if (b == 0) return 1'b0;
    if (b <= cfg_db[k]) return d[b-1];
    if (cfg_par[k] == 2 && b == cfg_db[k] + 1) return logic'(ones % 2);
    if (cfg_par[k] == 1 && b == cfg_db[k] + 1) return logic'(1 - (ones % 2));
    return 1'b1;
  endfunction

  task automatic start_frame(input int k, input logic [8:0] d);
    @(negedge clk);
    checks++;
    if (rdy_w[k] !== 1'b1) $display("FAIL start_ready k=%0d: tx_ready=%b, expected 1", k, rdy_w[k]);
    else passes++;
    data_a[k]  = d;
    valid_a[k] = 1'b1;
    @(posedge clk);
  endtask

  // Walks one frame from cycle T+1 through the tx_done cycle; scrambles tx_data mid-frame.
  task automatic check_frame(input int k, input logic [8:0] d, input logic hold,
                             input logic [8:0] nxt);
    int len;
    len = flen(k);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c == 1) begin
        valid_a[k] = hold;
        data_a[k]  = 9'($urandom);
      end
      checks++;
      if (tx_w[k] !== exp_bit(k, d, c) || busy_w[k] !== 1'b1 || done_w[k] !== 1'b0 ||
          rdy_w[k] !== 1'b0)
        $display("FAIL frame k=%0d d=%h cyc=%0d: tx=%b busy=%b done=%b rdy=%b, expected tx=%b busy=1 done=0 rdy=0",
                 k, d, c, tx_w[k], busy_w[k], done_w[k], rdy_w[k], exp_bit(k, d, c));
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (done_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || rdy_w[k] !== 1'b1 || tx_w[k] !== 1'b1)
      $display("FAIL done_cycle k=%0d d=%h: done=%b busy=%b rdy=%b tx=%b, expected 1 0 1 1",
               k, d, done_w[k], busy_w[k], rdy_w[k], tx_w[k]);
    else passes++;
    data_a[k] = nxt;
  endtask

  task automatic send_word(input int k, input logic [8:0] d);
    start_frame(k, d);
    check_frame(k, d, 1'b0, 9'($urandom));
    @(negedge clk);
    checks++;
    if (done_w[k] !== 1'b0 || busy_w[k] !== 1'b0 || rdy_w[k] !== 1'b1 || tx_w[k] !== 1'b1)
      $display("FAIL post_frame k=%0d: done=%b busy=%b rdy=%b tx=%b, expected 0 0 1 1",
               k, done_w[k], busy_w[k], rdy_w[k], tx_w[k]);
    else passes++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 || rdy_w[k] !== 1'b1)
        $display("FAIL reset_state k=%0d: tx=%b busy=%b done=%b rdy=%b, expected 1 0 0 1",
                 k, tx_w[k], busy_w[k], done_w[k], rdy_w[k]);
      else passes++;
    end
  endtask

  task automatic test_directed();
    send_word(0, 9'h0A5);
    send_word(1, 9'h055);
    send_word(2, 9'h055);
    send_word(2, 9'h007);
    send_word(3, 9'h17F);
    send_word(3, 9'h100);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++) send_word(k, 9'($urandom));
  endtask

  task automatic test_back_to_back();
    start_frame(0, 9'h001);
    check_frame(0, 9'h001, 1'b1, 9'h080);
    check_frame(0, 9'h080, 1'b1, 9'h0FF);
    check_frame(0, 9'h0FF, 1'b0, 9'h000);
    @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0)
      $display("FAIL b2b_end: tx=%b busy=%b done=%b, expected 1 0 0", tx_w[0], busy_w[0], done_w[0]);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int seen_done;
    start_frame(0, 9'h000);
    // Clock 18 lies in data bit 3 (clocks 17..20).
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) valid_a[0] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0)
      $display("FAIL async_reset: tx=%b busy=%b, expected 1 0", tx_w[0], busy_w[0]);
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0)
      $display("FAIL abandoned_frame: %0d cycles with done/space, expected 0", seen_done);
    else passes++;
    send_word(0, 9'h03C);
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int n;
    int got;
    @(negedge clk);
    brk_a[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (tx_w[0] !== 1'b0 || rdy_w[0] !== 1'b0 || busy_w[0] !== 1'b1)
        $display("FAIL break_space cyc=%0d: tx=%b rdy=%b busy=%b, expected 0 0 1",
                 c, tx_w[0], rdy_w[0], busy_w[0]);
      else passes++;
      if (c == 20) brk_a[0] = 1'b0;
    end
    for (int c = 1; c <= CPB; c++) begin
      @(negedge clk);
      checks++;
      if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b0 || busy_w[0] !== 1'b1)
        $display("FAIL break_mark cyc=%0d: tx=%b rdy=%b busy=%b, expected 1 0 1",
                 c, tx_w[0], rdy_w[0], busy_w[0]);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (rdy_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0)
      $display("FAIL break_end: rdy=%b busy=%b done=%b, expected 1 0 0", rdy_w[0], busy_w[0], done_w[0]);
    else passes++;

    // Break raised mid-frame waits for tx_done.
    start_frame(0, 9'h0C3);
    n = 0;
    got = 0;
    while (n < 200 && got == 0) begin
      @(negedge clk);
      n++;
      if (n == 1) valid_a[0] = 1'b0;
      if (n == 6) brk_a[0] = 1'b1;
      if (n < flen(0) + 1 && n > 6 && tx_w[0] !== exp_bit(0, 9'h0C3, n)) got = -1;
      if (done_w[0] === 1'b1) got = n;
    end
    checks++;
    if (got != flen(0) + 1)
      $display("FAIL deferred_break: done at cycle %0d, expected %0d", got, flen(0) + 1);
    else passes++;
    @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1)
      $display("FAIL break_after_done: tx=%b busy=%b, expected 0 1", tx_w[0], busy_w[0]);
    else passes++;
    brk_a[0] = 1'b0;
    repeat (CPB + 1) @(negedge clk);
    checks++;
    if (rdy_w[0] !== 1'b1 || tx_w[0] !== 1'b1)
      $display("FAIL break2_end: rdy=%b tx=%b, expected 1 1", rdy_w[0], tx_w[0]);
    else passes++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    valid_a = '0;
    brk_a   = '0;
    for (int k = 0; k < 4; k++) data_a[k] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name:
uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 baud-clocked transmitter. Runs on the system clock with an internal bit-period counter. Frame format is set at elaboration: data width, parity mode and stop-bit count. Sits between a byte-producing source (CPU/bus bridge or FIFO) and the TX pin, using a valid/ready handshake.

Parameters:
CLKS_PER_BIT, 16, system clocks per bit period; legal range >= 2; elaboration error otherwise.
DATA_BITS, 8, data bits per frame, sent LSB first; legal range 5..9; elaboration error otherwise.
PARITY, 0, 0 = none, 1 = odd, 2 = even; other values are an elaboration error.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_BITS  frame payload, sampled only at acceptance
tx_valid  input  1  source has a word to send
tx_ready  output  1  block can accept a word; high only in IDLE
tx  output  1  serial line, registered, idles high (mark)
tx_busy  output  1  high from the cycle after acceptance until the frame ends
tx_done  output  1  one-cycle pulse after the last stop-bit cycle

Behaviour:
- Reset (async assert, sync release): state = IDLE, bit counter = 0, clock counter = 0, tx = 1, tx_busy = 0, tx_done = 0, tx_ready = 1.
- tx_ready is combinational from the registered state: 1 exactly when state == IDLE and not in break (see Optional Feature).
- A word is accepted at a rising edge where tx_valid && tx_ready. tx_data is latched into a shift register on that edge. Later changes to tx_data are ignored.
- States: IDLE -> START -> DATA -> (PARITY if PARITY != 0) -> STOP -> IDLE.
- Bit timing: each state drives tx for exactly CLKS_PER_BIT cycles. The clock counter runs 0..CLKS_PER_BIT-1, and the state or bit advances on the edge where it equals CLKS_PER_BIT-1. Counter width is $clog2(CLKS_PER_BIT).
- Frame timing, with acceptance at edge T:
  - tx = 0 (start bit) from cycle T+1 for CLKS_PER_BIT cycles; tx_busy = 1 from T+1.
  - DATA: the shift register LSB is driven; it shifts right each bit period. The bit counter counts 0..DATA_BITS-1.
  - PARITY: the bit is the XOR of the latched data for even parity, inverted for odd parity. Odd parity makes the total count of ones, including the parity bit, odd.
  - STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length is N*CLKS_PER_BIT cycles, where N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
- End of frame: on the edge ending the last stop cycle, state -> IDLE, tx_busy -> 0, tx_done = 1 for one cycle, tx_ready = 1.
- Back-to-back: if tx_valid is held, the next word is accepted on the tx_done cycle edge. The next start bit then begins one cycle later, so exactly one extra mark cycle separates frames.
- tx_valid is ignored while tx_ready = 0. There is no queueing or overrun; the source must hold tx_valid until accepted.
- Reset mid-frame: tx returns to 1 immediately (async). The partial frame is abandoned and no tx_done is issued.
- tx never glitches: it is always a flop output.

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - Adds input port tx_break (1 bit).
  - When tx_break = 1 while in IDLE, the block enters BRK: tx = 0, tx_ready = 0, tx_busy = 1.
  - A tx_break asserted mid-frame is deferred until the frame's tx_done.
  - On tx_break falling, tx = 1 for a mandatory CLKS_PER_BIT-cycle mark (tx_busy still 1), then IDLE and tx_ready = 1. No tx_done is pulsed for a break.
- Undefined: the port is absent, there is no BRK state, and behaviour is exactly as above.

Test Plan:
- Defaults (8N1, CLKS_PER_BIT=4), send 0xA5 -> tx = 0, then bits 1,0,1,0,0,1,0,1, then 1, each for 4 cycles. Start at T+1, tx_done at T+41, tx_busy high for 40 cycles.
- PARITY=2, send 0x55 -> parity bit 0; PARITY=1, send 0x55 -> parity bit 1; PARITY=1, send 0x07 -> parity bit 0. Frame is 11 bit periods.
- DATA_BITS=7, STOP_BITS=2, PARITY=0, send 0x7F -> 7 ones after the start bit, then 2 bit periods of mark. tx_done at T+10*CLKS_PER_BIT+1. Bit 8 of any wider stimulus is not present.
- tx_valid held high with 3 words (0x01, 0x80, 0xFF) -> 3 frames, each separated by exactly one extra mark cycle. tx_ready is high only on the tx_done cycles. tx_data changed mid-frame does not alter the output.
- rst_n pulsed low during the DATA bit 3 of 0x00 -> tx = 1 asynchronously, no tx_done. After release, tx_ready = 1 and a fresh 0x3C is sent correctly.
- With UART_TX_BREAK_EN: tx_break held 20 cycles from IDLE (CLKS_PER_BIT=4) -> tx = 0 for 20 cycles, then 4 cycles mark, then tx_ready = 1. A break raised mid-frame starts only after that frame's tx_done.
